// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared posit<32,3> constants, pipeline FSM states and scale helper
package posit_pkg;

  localparam int ES      = 3;
  localparam int N       = 32;
  localparam int K_MAX   = 30;
  localparam int K_MIN   = -31;
  localparam int SCALE_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_MULT,
    ST_NORM,
    ST_DONE
  } posit_state_e;

  // 8*k + exp: exp is always below 8, so the scale is just k sign-extended with exp appended.
  function automatic logic signed [SCALE_W-1:0] posit_scale(input logic [5:0] k,
                                                            input logic [ES-1:0] e);
    return {{(SCALE_W-ES-6){k[5]}}, k, e};
  endfunction

endpackage

// File: rtl/posit_mant_mul.sv
// rtl/posit_mant_mul.sv - iterative shift-add unsigned multiplier, one partial product per cycle
module posit_mant_mul #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product,
  output logic           busy,
  output logic           valid
);

  localparam int CNT_W = $clog2(W);

  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc;
  logic [W-1:0]   mplier;
  logic [CNT_W-1:0] cnt;

  assign product = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
    end else if (start) begin
      mcand  <= {{W{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
      valid  <= 1'b0;
    end else if (busy) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(W-1)) begin
        busy  <= 1'b0;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/posit_field_multiplier.sv
// rtl/posit_field_multiplier.sv - multi-cycle posit<32,3> decoded-field multiply with normalise/saturate
module posit_field_multiplier #(
  parameter int ES     = 3,
  parameter int MANT_W = 32,
  parameter int K_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_sign,
  input  logic [K_W-1:0]    a_k,
  input  logic [ES-1:0]     a_exp,
  input  logic [MANT_W-1:0] a_mant,
  input  logic              a_zero,
  input  logic              a_nar,
  input  logic              a_done,
  input  logic              b_sign,
  input  logic [K_W-1:0]    b_k,
  input  logic [ES-1:0]     b_exp,
  input  logic [MANT_W-1:0] b_mant,
  input  logic              b_zero,
  input  logic              b_nar,
  input  logic              b_done,
  output logic              recieved,
  input  logic              out_recieved,
  output logic              done,
  output logic              sign,
  output logic [K_W-1:0]    k,
  output logic [ES-1:0]     exp_value,
  output logic [MANT_W-1:0] mantissa,
  output logic              ZERO,
  output logic              NAR,
  output logic              sticky,
  output logic              sat
);

  import posit_pkg::*;

  localparam int CNT_W = $clog2(MANT_W);
  localparam int P_W   = 2 * MANT_W;
  localparam logic signed [SCALE_W-1:0] KMAX_S = SCALE_W'(K_MAX);
  localparam logic signed [SCALE_W-1:0] KMIN_S = SCALE_W'(K_MIN);

  posit_state_e state;

  logic              la_sign, lb_sign;
  logic [K_W-1:0]    la_k, lb_k;
  logic [ES-1:0]     la_exp, lb_exp;
  logic [MANT_W-1:0] la_mant, lb_mant;
  logic              la_zero, lb_zero;
  logic              la_nar, lb_nar;
  logic [CNT_W-1:0]  cnt;

  logic              is_nar, is_zero;
  logic              mul_start, mul_busy, mul_valid;
  logic [P_W-1:0]    prod;

  logic signed [SCALE_W-1:0] rs, rs_n, rs_sh;
  logic              prod_hi;
  logic [MANT_W-1:0] norm_mant;
  logic              norm_sticky;
  logic              sat_hi, sat_lo;

  assign is_nar    = la_nar | lb_nar;
  assign is_zero   = la_zero | lb_zero;
  assign mul_start = (state == ST_ACK) && !is_nar && !is_zero;

  posit_mant_mul #(.W(MANT_W)) u_mant_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (la_mant),
    .b       (lb_mant),
    .product (prod),
    .busy    (mul_busy),
    .valid   (mul_valid)
  );

  // A product of two Q1.31 values lies in [1,4): a set top bit means one extra binade.
  always_comb begin
    prod_hi     = prod[P_W-1];
    rs          = posit_scale(la_k, la_exp) + posit_scale(lb_k, lb_exp);
    rs_n        = rs + (prod_hi ? SCALE_W'(1) : SCALE_W'(0));
    rs_sh       = rs_n >>> ES;
    norm_mant   = prod_hi ? prod[P_W-1 -: MANT_W] : prod[P_W-2 -: MANT_W];
    norm_sticky = prod_hi ? |prod[MANT_W-1:0] : |prod[MANT_W-2:0];
    sat_hi      = rs_sh > KMAX_S;
    sat_lo      = rs_sh < KMIN_S;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      recieved  <= 1'b0;
      done      <= 1'b0;
      sign      <= 1'b0;
      k         <= '0;
      exp_value <= '0;
      mantissa  <= '0;
      ZERO      <= 1'b0;
      NAR       <= 1'b0;
      sticky    <= 1'b0;
      sat       <= 1'b0;
      la_sign   <= 1'b0;
      la_k      <= '0;
      la_exp    <= '0;
      la_mant   <= '0;
      la_zero   <= 1'b0;
      la_nar    <= 1'b0;
      lb_sign   <= 1'b0;
      lb_k      <= '0;
      lb_exp    <= '0;
      lb_mant   <= '0;
      lb_zero   <= 1'b0;
      lb_nar    <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (a_done && b_done) begin
            la_sign  <= a_sign;
            la_k     <= a_k;
            la_exp   <= a_exp;
            la_mant  <= a_mant;
            la_zero  <= a_zero;
            la_nar   <= a_nar;
            lb_sign  <= b_sign;
            lb_k     <= b_k;
            lb_exp   <= b_exp;
            lb_mant  <= b_mant;
            lb_zero  <= b_zero;
            lb_nar   <= b_nar;
            recieved <= 1'b1;
            state    <= ST_ACK;
          end
        end
        ST_ACK: begin
          recieved <= 1'b0;
          cnt      <= '0;
          if (is_nar || is_zero) begin
            sign      <= 1'b0;
            k         <= '0;
            exp_value <= '0;
            mantissa  <= '0;
            sticky    <= 1'b0;
            sat       <= 1'b0;
            NAR       <= is_nar;
            ZERO      <= !is_nar;
            done      <= 1'b1;
            state     <= ST_DONE;
          end else begin
            state <= ST_MULT;
          end
        end
        ST_MULT: begin
          cnt <= cnt + CNT_W'(1);
          if ((&cnt) && mul_busy) begin
            state <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (mul_valid) begin
            sign   <= la_sign ^ lb_sign;
            ZERO   <= 1'b0;
            NAR    <= 1'b0;
            sticky <= norm_sticky;
            if (sat_hi || sat_lo) begin
              k         <= sat_hi ? K_W'(K_MAX) : K_W'(K_MIN);
              exp_value <= '0;
              mantissa  <= {1'b1, {(MANT_W-1){1'b0}}};
              sat       <= 1'b1;
            end else begin
              k         <= rs_sh[K_W-1:0];
              exp_value <= rs_n[ES-1:0];
              mantissa  <= norm_mant;
              sat       <= 1'b0;
            end
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_recieved) begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_posit_field_multiplier.sv
// tb/tb_posit_field_multiplier.sv - vector table, handshake corners and randomized model check
module tb_posit_field_multiplier;

  logic        clk, rst;
  logic        a_sign, b_sign, a_zero, b_zero, a_nar, b_nar, a_done, b_done;
  logic [5:0]  a_k, b_k;
  logic [2:0]  a_exp, b_exp;
  logic [31:0] a_mant, b_mant;
  logic        recieved, out_recieved, done;
  logic        sign, ZERO, NAR, sticky, sat;
  logic [5:0]  k;
  logic [2:0]  exp_value;
  logic [31:0] mantissa;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        as;
    logic [5:0]  ak;
    logic [2:0]  ae;
    logic [31:0] am;
    logic        az;
    logic        an;
    logic        bs;
    logic [5:0]  bk;
    logic [2:0]  be;
    logic [31:0] bm;
    logic        bz;
    logic        bn;
  } op_t;

  typedef struct {
    logic [45:0] f;
    int          lat;
  } exp_t;

  typedef struct {
    string       name;
    op_t         op;
    logic [45:0] f;
    int          lat;
  } vec_t;

  posit_field_multiplier dut (
    .clk(clk), .rst(rst),
    .a_sign(a_sign), .a_k(a_k), .a_exp(a_exp), .a_mant(a_mant),
    .a_zero(a_zero), .a_nar(a_nar), .a_done(a_done),
    .b_sign(b_sign), .b_k(b_k), .b_exp(b_exp), .b_mant(b_mant),
    .b_zero(b_zero), .b_nar(b_nar), .b_done(b_done),
    .recieved(recieved), .out_recieved(out_recieved), .done(done),
    .sign(sign), .k(k), .exp_value(exp_value), .mantissa(mantissa),
    .ZERO(ZERO), .NAR(NAR), .sticky(sticky), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [45:0] pk(input logic s, input logic [5:0] kk, input logic [2:0] e,
                                     input logic [31:0] m, input logic z, input logic n,
                                     input logic st, input logic sa);
    return {s, kk, e, m, z, n, st, sa};
  endfunction

  function automatic logic [45:0] pack_out();
    return {sign, k, exp_value, mantissa, ZERO, NAR, sticky, sat};
  endfunction

  function automatic op_t mk(input logic as, input logic [5:0] ak, input logic [2:0] ae,
                             input logic [31:0] am, input logic az, input logic an,
                             input logic bs, input logic [5:0] bk, input logic [2:0] be,
                             input logic [31:0] bm, input logic bz, input logic bn);
    op_t o;
    o = '{as, ak, ae, am, az, an, bs, bk, be, bm, bz, bn};
    return o;
  endfunction

  // Reference: real-valued scale arithmetic with floor division, 64-bit integer product.
  function automatic exp_t model(input op_t o);
    exp_t r;
    longint unsigned ma, mb, p;
    int ka, kb, ea, eb, rs, kk, ex;
    logic [31:0] m;
    logic st, sa;
    r.lat = 1;
    if (o.an || o.bn) begin
      r.f = pk(0, 0, 0, 0, 0, 1, 0, 0);
      return r;
    end
    if (o.az || o.bz) begin
      r.f = pk(0, 0, 0, 0, 1, 0, 0, 0);
      return r;
    end
    ma = o.am; mb = o.bm;
    p  = ma * mb;
    ka = $signed(o.ak); kb = $signed(o.bk);
    ea = o.ae; eb = o.be;
    rs = 8 * ka + ea + 8 * kb + eb;
    if (p[63]) begin
      rs = rs + 1;
      m  = p[63:32];
      st = |p[31:0];
    end else begin
      m  = p[62:31];
      st = |p[30:0];
    end
    kk = (rs >= 0) ? rs / 8 : -((-rs + 7) / 8);
    ex = rs - 8 * kk;
    sa = 1'b0;
    if (kk > 30) begin
      kk = 30; ex = 0; m = 32'h80000000; sa = 1'b1;
    end else if (kk < -31) begin
      kk = -31; ex = 0; m = 32'h80000000; sa = 1'b1;
    end
    r.f   = pk(o.as ^ o.bs, 6'(kk), 3'(ex), m, 0, 0, st, sa);
    r.lat = 34;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic drive(input op_t o);
    a_sign = o.as; a_k = o.ak; a_exp = o.ae; a_mant = o.am; a_zero = o.az; a_nar = o.an;
    b_sign = o.bs; b_k = o.bk; b_exp = o.be; b_mant = o.bm; b_zero = o.bz; b_nar = o.bn;
  endtask

  task automatic apply_op(input op_t o, input bit release_it, output logic [45:0] got,
                          output int lat, output int rc, output bit to);
    drive(o);
    a_done = 1'b1; b_done = 1'b1;
    to = 1'b0; rc = 0; lat = 0; got = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (recieved) begin
        rc = 1;
        break;
      end
    end
    a_done = 1'b0; b_done = 1'b0;
    if (rc == 0) begin
      to = 1'b1;
      return;
    end
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      lat++;
      if (recieved) rc++;
      if (done) break;
    end
    if (!done) to = 1'b1;
    got = pack_out();
    if (release_it) begin
      out_recieved = 1'b1;
      @(posedge clk); #1;
      out_recieved = 1'b0;
    end
  endtask

  vec_t vt[9];
  op_t one_one, o15, ro;
  exp_t e;
  logic [45:0] got, snap;
  int lat, rc, cnt, bad;
  bit to;

  initial begin
    one_one = mk(0, 6'h00, 0, 32'h80000000, 0, 0, 0, 6'h00, 0, 32'h80000000, 0, 0);
    o15     = mk(0, 6'h00, 0, 32'hC0000000, 0, 0, 1, 6'h00, 0, 32'hC0000000, 0, 0);
    vt[0] = '{"one_x_one",   one_one, pk(0, 6'h00, 0, 32'h80000000, 0, 0, 0, 0), 34};
    vt[1] = '{"1p5_x_m1p5",  o15,     pk(1, 6'h00, 1, 32'h90000000, 0, 0, 0, 0), 34};
    vt[2] = '{"scale_carry", mk(0, 6'h00, 7, 32'h80000000, 0, 0, 0, 6'h00, 1, 32'h80000000, 0, 0),
              pk(0, 6'h01, 0, 32'h80000000, 0, 0, 0, 0), 34};
    vt[3] = '{"neg_scale",   mk(0, 6'h3F, 0, 32'h80000000, 0, 0, 0, 6'h00, 3, 32'h80000000, 0, 0),
              pk(0, 6'h3F, 3, 32'h80000000, 0, 0, 0, 0), 34};
    vt[4] = '{"sticky",      mk(0, 6'h00, 0, 32'h80000001, 0, 0, 0, 6'h00, 0, 32'h80000001, 0, 0),
              pk(0, 6'h00, 0, 32'h80000002, 0, 0, 1, 0), 34};
    vt[5] = '{"nar_x_zero",  mk(0, 6'h00, 0, 32'h0, 0, 1, 0, 6'h00, 0, 32'h0, 1, 0),
              pk(0, 6'h00, 0, 32'h0, 0, 1, 0, 0), 1};
    vt[6] = '{"zero_x_b",    mk(0, 6'h00, 0, 32'h0, 1, 0, 1, 6'h00, 0, 32'hC0000000, 0, 0),
              pk(0, 6'h00, 0, 32'h0, 1, 0, 0, 0), 1};
    vt[7] = '{"sat_hi",      mk(0, 6'h1E, 7, 32'h80000000, 0, 0, 0, 6'h1E, 7, 32'h80000000, 0, 0),
              pk(0, 6'h1E, 0, 32'h80000000, 0, 0, 0, 1), 34};
    vt[8] = '{"sat_lo",      mk(0, 6'h21, 0, 32'h80000000, 0, 0, 0, 6'h21, 0, 32'h80000000, 0, 0),
              pk(0, 6'h21, 0, 32'h80000000, 0, 0, 0, 1), 34};

    rst = 1'b1; out_recieved = 1'b0; a_done = 1'b0; b_done = 1'b0;
    drive(one_one);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {18'b0, pack_out(), done, recieved}, 64'h0);
    rst = 1'b0;

    // A lone decoder done must never be acknowledged.
    a_done = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (recieved) cnt++;
    end
    a_done = 1'b0;
    check("single_done_no_ack", cnt, 0);

    foreach (vt[i]) begin
      apply_op(vt[i].op, 1'b1, got, lat, rc, to);
      check({vt[i].name, "_timeout"}, to, 0);
      check({vt[i].name, "_fields"}, got, vt[i].f);
      check({vt[i].name, "_latency"}, lat, vt[i].lat);
      check({vt[i].name, "_ack_pulses"}, rc, 1);
    end

    // Hold in DONE without downstream acknowledge.
    apply_op(o15, 1'b0, got, lat, rc, to);
    check("hold_timeout", to, 0);
    snap = pack_out();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (pack_out() !== snap || done !== 1'b1) bad++;
    end
    check("hold_stable", bad, 0);
    check("hold_fields", snap, pk(1, 6'h00, 1, 32'h90000000, 0, 0, 0, 0));

    // Release and new operands in the same cycle: capture must wait one edge.
    drive(one_one);
    out_recieved = 1'b1; a_done = 1'b1; b_done = 1'b1;
    @(posedge clk); #1;
    out_recieved = 1'b0;
    check("same_cycle_no_capture", {done, recieved}, 2'b00);
    @(posedge clk); #1;
    check("same_cycle_capture", recieved, 1);
    a_done = 1'b0; b_done = 1'b0;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) break;
      @(posedge clk); #1;
      lat++;
    end
    check("same_cycle_latency", lat, 34);
    check("same_cycle_fields", pack_out(), pk(0, 6'h00, 0, 32'h80000000, 0, 0, 0, 0));
    out_recieved = 1'b1;
    @(posedge clk); #1;
    out_recieved = 1'b0;

    // Reset while the multiplier is on its 15th iteration.
    drive(o15);
    a_done = 1'b1; b_done = 1'b1;
    rc = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (recieved) begin
        rc = 1;
        break;
      end
    end
    a_done = 1'b0; b_done = 1'b0;
    check("midmult_ack", rc, 1);
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midmult_reset_outputs", {18'b0, pack_out(), done, recieved}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midmult_idle", {done, recieved}, 2'b00);
    apply_op(one_one, 1'b1, got, lat, rc, to);
    check("post_reset_timeout", to, 0);
    check("post_reset_fields", got, pk(0, 6'h00, 0, 32'h80000000, 0, 0, 0, 0));
    check("post_reset_latency", lat, 34);

    for (int n = 0; n < 60; n++) begin
      ro.as = 1'($urandom_range(1));
      ro.ak = 6'(int'($urandom_range(61)) - 31);
      ro.ae = 3'($urandom_range(7));
      ro.am = 32'h80000000 | $urandom();
      ro.az = ($urandom_range(15) == 0);
      ro.an = ($urandom_range(23) == 0);
      ro.bs = 1'($urandom_range(1));
      ro.bk = 6'(int'($urandom_range(61)) - 31);
      ro.be = 3'($urandom_range(7));
      ro.bm = 32'h80000000 | $urandom();
      ro.bz = ($urandom_range(15) == 0);
      ro.bn = ($urandom_range(23) == 0);
      e = model(ro);
      apply_op(ro, 1'b1, got, lat, rc, to);
      check($sformatf("rand%0d_timeout", n), to, 0);
      check($sformatf("rand%0d_fields", n), got, e.f);
      check($sformatf("rand%0d_latency", n), lat, e.lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
